dpram_stream_reader: RTL and testbench

- Read-side master for the project's dual-port RAM.
- Drives the RAM read port (address, enable) and converts a block request (base address, word count) into a valid/ready output stream with last-word marking.
- Absorbs the RAM's one-cycle registered-address read latency with a 2-entry skid buffer, so downstream backpressure never loses or duplicates words.
- Sits between a RAM filled by a writer on port A and a consumer such as a DMA, scanout or audio path.

---
 rtl/dpram_stream_reader_pkg.sv | 19 +
 rtl/skid_fifo2.sv | 73 +++++++
 rtl/dpram_stream_reader.sv | 133 +++++++++++++
 tb/tb_dpram_stream_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// dpram_stream_reader_pkg
// Shared definitions for the dual-port RAM stream reader and its skid FIFO:
//   state_t     - reader FSM state encoding (IDLE, RUN, DONE)
//   SKID_DEPTH  - number of words the skid buffer can hold
//   OCC_WIDTH   - width of an occupancy count covering 0..SKID_DEPTH
// -----------------------------------------------------------------------------
package dpram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/skid_fifo2.sv
// -----------------------------------------------------------------------------
// skid_fifo2
// Two-entry FIFO that absorbs the RAM read latency in front of the output
// stream. Entry 0 is always the head, so the head needs no read mux.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-high reset (empties the FIFO)
//   push       in   write push_data this cycle (caller never pushes when full)
//   push_data  in   entry written on push
//   pop        in   remove the head this cycle (ignored when empty)
//   head_data  out  current head entry (meaningful when occupancy != 0)
//   occupancy  out  number of stored entries, 0..SKID_DEPTH
// -----------------------------------------------------------------------------
module skid_fifo2
    import dpram_stream_reader_pkg::*;
#(
    parameter int width = 9
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic [width-1:0]     push_data,
    input  logic                 pop,
    output logic [width-1:0]     head_data,
    output logic [OCC_WIDTH-1:0] occupancy
);

    logic [width-1:0]     entry0;
    logic [width-1:0]     entry1;
    logic [OCC_WIDTH-1:0] count;
    logic                 do_pop;

    assign do_pop    = pop && (count != '0);
    assign head_data = entry0;
    assign occupancy = count;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples its inputs as they were before the clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (push && !do_pop) begin
            count <= count + OCC_WIDTH'(1);
        end else if (!push && do_pop) begin
            count <= count - OCC_WIDTH'(1);
        end
    end

    // NOTE: the storage entries are deliberately left out of reset; the count
    // alone decides what is valid, so the data registers need no reset net.
    always_ff @(posedge clock) begin
        case ({push, do_pop})
            2'b10: begin
                if (count == '0) entry0 <= push_data;
                else             entry1 <= push_data;
            end
            2'b01: begin
                entry0 <= entry1;
            end
            2'b11: begin
                // Head leaves; the new word lands behind whatever remains.
                if (count == OCC_WIDTH'(1)) begin
                    entry0 <= push_data;
                end else begin
                    entry0 <= entry1;
                    entry1 <= push_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dpram_stream_reader.sv
// -----------------------------------------------------------------------------
// dpram_stream_reader
// Read-side master for the dual-port RAM. Turns a (base_addr, length) block
// request into a valid/ready stream with last-word marking, hiding the RAM's
// one-cycle registered read latency behind a 2-entry skid FIFO.
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   start                request strobe, sampled only in IDLE
//   base_addr, length    block request (length 0..2**addr_width)
//   busy                 high from the cycle after start through the done cycle
//   done                 one-cycle pulse after the last word's handshake
//   ram_address          RAM read-port address
//   ram_enable           RAM read-port enable, high only on an issued read
//   ram_q                RAM read data, valid the cycle after an issued read
//   out_data, out_valid, out_ready, out_last   output stream
// -----------------------------------------------------------------------------
module dpram_stream_reader
    import dpram_stream_reader_pkg::*;
#(
    parameter int addr_width = 8,
    parameter int data_width = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width-1:0] base_addr,
    input  logic [addr_width:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [addr_width-1:0] ram_address,
    output logic                  ram_enable,
    input  logic [data_width-1:0] ram_q,
    output logic [data_width-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    state_t                 state;
    state_t                 state_next;
    logic [addr_width-1:0]  addr_cnt;
    logic [addr_width:0]    remaining;
    logic                   in_flight;
    logic                   in_flight_last;
    logic [OCC_WIDTH-1:0]   occupancy;
    logic [data_width:0]    head;
    logic                   pop;
    logic                   issue;
    logic                   drained;
    logic [OCC_WIDTH:0]     slots_used;

    assign pop = out_valid && out_ready;

    // Words already committed to the buffer once this cycle settles: stored
    // plus in flight, minus one if the head leaves on this edge.
    assign slots_used = {1'b0, occupancy}
                      + {{OCC_WIDTH{1'b0}}, in_flight}
                      - {{OCC_WIDTH{1'b0}}, pop};

    assign issue = (state == RUN) && (remaining != '0)
                && (slots_used < (OCC_WIDTH+1)'(SKID_DEPTH));

    // Block is finished once nothing is left to issue and the last stored
    // word leaves on this edge (or already left), so done follows the final
    // handshake directly.
    assign drained = (remaining == '0) && (slots_used == '0);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = (length == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (drained) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            remaining <= '0;
            in_flight <= 1'b0;
        end else begin
            if (state == IDLE && start) remaining <= length;
            else if (issue)             remaining <= remaining - (addr_width+1)'(1);
            in_flight <= issue;
        end
    end

    // Address counter and last tag are always loaded before they are used.
    always_ff @(posedge clock) begin
        if (state == IDLE && start) addr_cnt <= base_addr;
        else if (issue)             addr_cnt <= addr_cnt + addr_width'(1);
        if (issue) in_flight_last <= (remaining == (addr_width+1)'(1));
    end

    assign ram_address = addr_cnt;
    assign ram_enable  = issue;

    skid_fifo2 #(
        .width (data_width + 1)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (in_flight),
        .push_data ({in_flight_last, ram_q}),
        .pop       (pop),
        .head_data (head),
        .occupancy (occupancy)
    );

    assign out_valid = (occupancy != '0);
    assign out_data  = head[data_width-1:0];
    assign out_last  = out_valid && head[data_width];

endmodule

// File: tb/tb_dpram_stream_reader.sv
module tb_dpram_stream_reader;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_address;
    logic          ram_enable;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [5:0]    toggle_pat = 6'b101001;   // ready sequence 1,0,0,1,0,1 (bit 0 first)

    dpram_stream_reader #(
        .addr_width (AW),
        .data_width (DW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .ram_address (ram_address),
        .ram_enable  (ram_enable),
        .ram_q       (ram_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last)
    );

    always #5 clock = ~clock;

    // RAM read port: registered address, data one cycle after an enabled edge.
    always @(posedge clock) begin
        if (ram_enable) ram_q <= mem[ram_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return toggle_pat[c % 6];
            default: return 1'b1 & 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Runs one block; entered and left just after a rising edge.
    task automatic run_block(input logic [AW-1:0] b, input int len, input int mode,
                             input bit second_start);
        logic [DW:0]   exp_q[$];
        logic [AW-1:0] addr_q[$];
        logic [DW:0]   e;
        logic [DW-1:0] prev_data;
        bit            prev_stall, saw_done, hs;
        int            issued, accepted, lasts, c, budget, first_valid, last_hs;

        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            a = b + AW'(i);
            addr_q.push_back(a);
            exp_q.push_back({(i == len - 1), mem[a]});
        end

        issued = 0; accepted = 0; lasts = 0; c = 0;
        first_valid = -1; last_hs = -1;
        prev_stall = 1'b0; saw_done = 1'b0; prev_data = '0;
        budget = 4 * len + 20;

        start     = 1'b1;
        base_addr = b;
        length    = (AW+1)'(len);
        out_ready = ready_for(mode, 0);
        @(posedge clock); #1;
        start = 1'b0;

        while (!saw_done && c < budget) begin
            out_ready = ready_for(mode, c);
            if (second_start && c == 3) begin
                start     = 1'b1;
                base_addr = b + 8'h40;
                length    = 9'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            check("busy", busy, 1);
            if (c == 0 && len > 0) check("first_issue", ram_enable, 1);
            hs = out_valid && out_ready;
            if (ram_enable) begin
                check("issue_window", (issued - accepted - int'(hs)) < 2, 1);
                if (addr_q.size() == 0) check("extra_issue", 1, 0);
                else                    check("ram_address", ram_address, addr_q.pop_front());
                issued++;
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid && first_valid < 0) begin
                first_valid = c;
                if (mode == 0) check("first_valid_cycle", c, 2);
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data", out_data, e[DW-1:0]);
                    check("last", out_last, e[DW]);
                end
                if (out_last) lasts++;
                accepted++;
                last_hs = c;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) begin
                saw_done = 1'b1;
                check("done_timing", c, (len == 0) ? 0 : last_hs + 1);
            end
            @(posedge clock); #1;
            c++;
        end

        start = 1'b0;
        if (!saw_done) check("timeout", 0, 1);
        check("words_left", exp_q.size(), 0);
        check("issue_count", issued, len);
        check("last_count", lasts, (len > 0) ? 1 : 0);
        if (mode == 0 && len > 0) check("throughput", last_hs, len + 1);
        if (len == 0) check("zero_no_valid", first_valid, -1);

        @(negedge clock);
        check("busy_after", busy, 0);
        check("done_after", done, 0);
        check("valid_after", out_valid, 0);
        @(posedge clock); #1;
    endtask

    task automatic reset_mid_block(input logic [AW-1:0] b);
        int seen, c;
        seen = 0; c = 0;
        start     = 1'b1;
        base_addr = b;
        length    = 9'd8;
        out_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        while (seen < 2 && c < 20) begin
            @(negedge clock);
            if (out_valid && out_ready) begin
                check("rst_blk_data", out_data, mem[b + AW'(seen)]);
                seen++;
            end
            @(posedge clock); #1;
            c++;
        end
        check("rst_blk_reached", seen, 2);

        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_enable", ram_enable, 0);
        check("rst_done", done, 0);
        repeat (5) begin
            @(posedge clock); #1;
            @(negedge clock);
            check("rst_no_done", done, 0);
            check("rst_idle_valid", out_valid, 0);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_valid", out_valid, 0);
        check("reset_last", out_last, 0);
        check("reset_ram_enable", ram_enable, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        run_block(8'h10, 4, 0, 1'b0);     // basic block
        run_block(8'hFE, 4, 0, 1'b0);     // address wrap
        run_block(8'h20, 6, 1, 1'b0);     // toggling backpressure
        run_block(8'h00, 0, 0, 1'b0);     // zero length
        run_block(8'h80, 256, 0, 1'b0);   // full RAM, wraps through 0
        run_block(8'h30, 4, 0, 1'b1);     // start while busy is ignored

        reset_mid_block(8'h50);
        run_block(8'h61, 5, 0, 1'b0);     // fresh block after reset

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        for (int n = 0; n < 25; n++) begin
            run_block(AW'($urandom_range(0, DEPTH - 1)), $urandom_range(0, 20),
                      $urandom_range(0, 2), 1'b0);
        end
        run_block(AW'($urandom_range(0, DEPTH - 1)), 256, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
